rtc_timer_unit: RTL and testbench

- Parametrised successor to the CSR-side real-time counter.
- Prescaler divides clk into time units and drives a COUNT_LEN-bit real-time count that software can load.
- Adds NUM_CMP compare channels, each one-shot or periodic, with sticky interrupt flags, a wrap pulse and an enable gate.
- Sits in the CSR block and feeds the time/timeh CSR reads and the machine timer interrupt.

---
 rtl/rtc_timer_unit.sv | 133 +++++++++++++
 tb/tb_rtc_timer_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timer_unit.sv
// Real-time counter with prescaler, software load and NUM_CMP compare channels.
// Optional macro RTC_PRESCALE_EN enables the TICKS_PER_UNIT prescaler.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                count enable (prescaler and count hold when low)
//   load_valid/data   load real-time count, clears prescaler
//   cmp_we            per-channel compare write strobe (arms channel)
//   cmp_periodic      mode with cmp_we: 0 one-shot, 1 periodic
//   cmp_wdata         absolute compare (one-shot) or interval (periodic)
//   irq_clr           per-channel sticky flag clear
//   real_time_out     registered count
//   tick / wrap       one-cycle pulses after increment / all-ones->0 wrap
//   irq               sticky per-channel interrupt flags
module rtc_timer_unit #(
  parameter int COUNT_LEN      = 64,
  parameter int PRESC_W        = 32,
  parameter int TICKS_PER_UNIT = 1000000000,
  parameter int NUM_CMP        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load_valid,
  input  logic [COUNT_LEN-1:0] load_data,
  input  logic [NUM_CMP-1:0]   cmp_we,
  input  logic [NUM_CMP-1:0]   cmp_periodic,
  input  logic [COUNT_LEN-1:0] cmp_wdata,
  input  logic [NUM_CMP-1:0]   irq_clr,
  output logic [COUNT_LEN-1:0] real_time_out,
  output logic                 tick,
  output logic                 wrap,
  output logic [NUM_CMP-1:0]   irq
);

  localparam logic [COUNT_LEN-1:0] ONES = '1;
  localparam logic [COUNT_LEN-1:0] ONE  = COUNT_LEN'(1);

  logic unit_done;

`ifdef RTC_PRESCALE_EN
  localparam logic [PRESC_W-1:0] PRESC_MAX =
    PRESC_W'(TICKS_PER_UNIT - 1);

  logic [PRESC_W-1:0] presc;

  assign unit_done = en && (presc == PRESC_MAX);

  // A load restarts the time unit so the next increment
  // lands a full TICKS_PER_UNIT enabled cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (load_valid || unit_done) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + PRESC_W'(1);
    end
  end
`else
  assign unit_done = en;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      real_time_out <= '0;
      tick          <= 1'b0;
      wrap          <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load_valid) begin
        real_time_out <= load_data;
      end else if (unit_done) begin
        real_time_out <= real_time_out + ONE;
        tick          <= 1'b1;
        wrap          <= (real_time_out == ONES);
      end
    end
  end

  logic [COUNT_LEN-1:0] cmp  [NUM_CMP];
  logic [COUNT_LEN-1:0] intv [NUM_CMP];
  logic [NUM_CMP-1:0]   armed;
  logic [NUM_CMP-1:0]   periodic;
  logic [NUM_CMP-1:0]   match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      match[i] = armed[i] && (real_time_out >= cmp[i]);
    end
  end

  // A write wins over a same-cycle match; a set wins
  // over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed    <= '0;
      periodic <= '0;
      irq      <= '0;
      for (int i = 0; i < NUM_CMP; i++) begin
        cmp[i]  <= '0;
        intv[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        if (cmp_we[i]) begin
          armed[i]    <= 1'b1;
          periodic[i] <= cmp_periodic[i];
          if (cmp_periodic[i]) begin
            intv[i] <= cmp_wdata;
            cmp[i]  <= real_time_out + cmp_wdata;
          end else begin
            cmp[i] <= cmp_wdata;
          end
        end else if (match[i]) begin
          if (periodic[i] && (intv[i] != '0)) begin
            cmp[i] <= cmp[i] + intv[i];
          end else begin
            armed[i] <= 1'b0;
          end
        end
        if (match[i] && !cmp_we[i]) begin
          irq[i] <= 1'b1;
        end else if (irq_clr[i]) begin
          irq[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_timer_unit.sv
// Self-checking bench for rtc_timer_unit.
// Reference model pushes expected outputs per cycle; compared after each edge.
module tb_rtc_timer_unit;

`ifdef RTC_PRESCALE_EN
  localparam int TPU = 4;
`else
  localparam int TPU = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load_valid;
  logic [63:0] load_data;
  logic [1:0]  cmp_we;
  logic [1:0]  cmp_periodic;
  logic [63:0] cmp_wdata;
  logic [1:0]  irq_clr;
  logic [63:0] real_time_out;
  logic        tick;
  logic        wrap;
  logic [1:0]  irq;

  always #5 clk = ~clk;

  rtc_timer_unit #(
    .COUNT_LEN(64),
    .PRESC_W(32),
    .TICKS_PER_UNIT(4),
    .NUM_CMP(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .load_valid(load_valid),
    .load_data(load_data),
    .cmp_we(cmp_we),
    .cmp_periodic(cmp_periodic),
    .cmp_wdata(cmp_wdata),
    .irq_clr(irq_clr),
    .real_time_out(real_time_out),
    .tick(tick),
    .wrap(wrap),
    .irq(irq)
  );

  typedef struct packed {
    logic [63:0] rt;
    logic        tk;
    logic        wr;
    logic [1:0]  iq;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [63:0] m_rt;
  int          m_presc;
  logic        m_tick, m_wrap;
  logic [1:0]  m_irq, m_armed, m_per;
  logic [63:0] m_cmp [2];
  logic [63:0] m_int [2];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic mt;
    logic set;
    if (!rst_n) begin
      m_rt = '0; m_presc = 0; m_tick = 0; m_wrap = 0;
      m_irq = '0; m_armed = '0; m_per = '0;
      for (int i = 0; i < 2; i++) begin
        m_cmp[i] = '0; m_int[i] = '0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      mt  = m_armed[i] && (m_rt >= m_cmp[i]);
      set = 1'b0;
      if (cmp_we[i]) begin
        m_armed[i] = 1'b1;
        m_per[i]   = cmp_periodic[i];
        if (cmp_periodic[i]) begin
          m_int[i] = cmp_wdata;
          m_cmp[i] = m_rt + cmp_wdata;
        end else begin
          m_cmp[i] = cmp_wdata;
        end
      end else if (mt) begin
        set = 1'b1;
        if (m_per[i] && m_int[i] != 0) m_cmp[i] = m_cmp[i] + m_int[i];
        else m_armed[i] = 1'b0;
      end
      if (set) m_irq[i] = 1'b1;
      else if (irq_clr[i]) m_irq[i] = 1'b0;
    end
    m_tick = 0;
    m_wrap = 0;
    if (load_valid) begin
      m_rt = load_data;
      m_presc = 0;
    end else if (en) begin
      if (m_presc == TPU - 1) begin
        m_presc = 0;
        m_wrap  = (m_rt == 64'hFFFF_FFFF_FFFF_FFFF);
        m_rt    = m_rt + 64'd1;
        m_tick  = 1;
      end else begin
        m_presc++;
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    sb.push_back('{m_rt, m_tick, m_wrap, m_irq});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("rt", real_time_out, e.rt);
    check("tick", 64'(tick), 64'(e.tk));
    check("wrap", 64'(wrap), 64'(e.wr));
    check("irq", 64'(irq), 64'(e.iq));
    load_valid = 0;
    cmp_we     = '0;
    irq_clr    = '0;
  endtask

  initial begin
    logic [1:0]  prev;
    logic [63:0] hold;
    int          rises, wraps, ticks;
    rst_n = 0; en = 0; load_valid = 0; load_data = '0;
    cmp_we = '0; cmp_periodic = '0; cmp_wdata = '0; irq_clr = '0;
    m_rt = '0; m_presc = 0; m_tick = 0; m_wrap = 0;
    m_irq = '0; m_armed = '0; m_per = '0;
    for (int i = 0; i < 2; i++) begin
      m_cmp[i] = '0; m_int[i] = '0;
    end

    cyc(); cyc();
    check("reset_rt", real_time_out, 64'd0);
    rst_n = 1;
    en = 1;
    for (int i = 0; i < TPU; i++) cyc();
    check("rt_after_1unit", real_time_out, 64'd1);
    for (int i = 0; i < TPU; i++) cyc();
    check("rt_after_2unit", real_time_out, 64'd2);

    load_valid = 1; load_data = 64'd0; cyc();
    cmp_we = 2'b01; cmp_periodic = 2'b00; cmp_wdata = 64'd10; cyc();
    for (int i = 0; i < 12 * TPU; i++) cyc();
    check("os_fired", 64'(irq[0]), 64'd1);
    irq_clr = 2'b01; cyc();
    check("os_cleared", 64'(irq[0]), 64'd0);
    cmp_we = 2'b01; cmp_wdata = 64'd5; cyc();
    irq_clr = 2'b01; cyc();
    check("set_beats_clr", 64'(irq[0]), 64'd1);

    load_valid = 1; load_data = 64'd3; cyc();
    cmp_we = 2'b10; cmp_periodic = 2'b10; cmp_wdata = 64'd5; cyc();
    rises = 0;
    prev = irq;
    for (int i = 0; i < 16 * TPU + 1; i++) begin
      irq_clr = {m_irq[1], 1'b0};
      cyc();
      if (irq[1] && !prev[1]) rises++;
      prev = irq;
    end
    check("per_fires", 64'(rises), 64'd3);

    load_valid = 1; load_data = 64'hFFFF_FFFF_FFFF_FFFE; cyc();
    wraps = 0;
    for (int i = 0; i < 2 * TPU; i++) begin
      cyc();
      if (wrap) wraps++;
    end
    check("wrap_rt", real_time_out, 64'd0);
    check("wrap_cnt", 64'(wraps), 64'd1);
    for (int i = 0; i < TPU && m_presc != TPU - 1; i++) cyc();
    load_valid = 1; load_data = 64'h1234; cyc();
    check("load_edge_rt", real_time_out, 64'h1234);
    check("load_edge_tick", 64'(tick), 64'd0);

    cyc(); cyc();
    en = 0;
    hold = m_rt;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick) ticks++;
    end
    check("freeze_rt", real_time_out, hold);
    check("freeze_tick", 64'(ticks), 64'd0);
    en = 1;
    for (int i = 0; i < TPU; i++) cyc();
    check("resume_rt", real_time_out, hold + 64'd1);

    cmp_we = 2'b11; cmp_periodic = 2'b10;
    cmp_wdata = 64'd100; cyc();
    cmp_we = 2'b01; cmp_periodic = 2'b00; cmp_wdata = 64'd0; cyc();
    cyc();
    check("pre_rst_irq", 64'(irq[0]), 64'd1);
    rst_n = 0; cyc();
    check("rst_rt", real_time_out, 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst_n = 1;
    for (int i = 0; i < 3 * TPU; i++) cyc();
    check("disarmed_irq", 64'(irq), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
